// File: rtl/fifo_cam.sv
// fifo_cam: dual-clock FIFO carrying 17-bit camera words from clk to rd_clk.
// Gray-coded pointers cross domains through 2-flop synchronizers; standard (non-FWFT) read.
`timescale 1ns/1ps
module fifo_cam #(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_clk,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0] wrst_sync;
  logic [1:0] rrst_sync;
  logic       wrst_n;
  logic       rrst_n;

  // Per-domain reset: asserts with reset_n, releases two local edges later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrst_sync <= '0;
    else          wrst_sync <= {wrst_sync[0], 1'b1};
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) rrst_sync <= '0;
    else          rrst_sync <= {rrst_sync[0], 1'b1};
  end

  assign wrst_n = wrst_sync[1];
  assign rrst_n = rrst_sync[1];

  logic [ADDR_WIDTH:0] wbin, wgray, wbin_next, wgray_next;
  logic [ADDR_WIDTH:0] wq1_rgray, wq2_rgray;
  logic                wr_ok, full_next;

  logic [ADDR_WIDTH:0] rbin, rgray, rbin_next, rgray_next;
  logic [ADDR_WIDTH:0] rq1_wgray, rq2_wgray;
  logic                rd_ok, empty_next;

  always_comb begin
    wr_ok      = wr_en && !full;
    wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wr_ok};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Full when the write pointer is exactly one lap ahead of the read pointer
    full_next  = (wgray_next == {~wq2_rgray[ADDR_WIDTH:ADDR_WIDTH-1],
                                 wq2_rgray[ADDR_WIDTH-2:0]});
  end

  always_ff @(posedge clk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin      <= '0;
      wgray     <= '0;
      wq1_rgray <= '0;
      wq2_rgray <= '0;
      full      <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wgray     <= wgray_next;
      wq1_rgray <= rgray;
      wq2_rgray <= wq1_rgray;
      full      <= full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wbin[ADDR_WIDTH-1:0]] <= data;
  end

  always_comb begin
    rd_ok      = rd_en && !empty;
    rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, rd_ok};
    rgray_next = (rbin_next >> 1) ^ rbin_next;
    empty_next = (rgray_next == rq2_wgray);
  end

  always_ff @(posedge rd_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rgray     <= '0;
      rq1_wgray <= '0;
      rq2_wgray <= '0;
      empty     <= 1'b1;
      q         <= '0;
    end else begin
      rbin      <= rbin_next;
      rgray     <= rgray_next;
      rq1_wgray <= wgray;
      rq2_wgray <= rq1_wgray;
      empty     <= empty_next;
      if (rd_ok) q <= mem[rbin[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_fifo_cam.sv
// tb_fifo_cam: directed bench for fifo_cam with a queue model of FIFO contents.
// A per-cycle compare process checks q and flag pessimism against the model.
`timescale 1ns/1ps
module tb_fifo_cam;

  localparam int DW    = 17;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk     = 1'b0;
  logic          rd_clk  = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en   = 1'b0;
  logic          rd_en   = 1'b0;
  logic [DW-1:0] data    = '0;
  logic [DW-1:0] q;
  logic          empty;
  logic          full;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model[$];
  logic [DW-1:0] popped[$];
  logic [DW-1:0] exp_q = '0;

  fifo_cam #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .rd_clk(rd_clk), .data(data),
    .wr_en(wr_en), .rd_en(rd_en), .q(q), .empty(empty), .full(full)
  );

  always #18.5 clk = ~clk;
  always #11.5 rd_clk = ~rd_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Model: every accepted write enters the queue
  always @(posedge clk) begin
    if (reset_n && wr_en && !full) begin
      chk("full_pessimism", model.size() < DEPTH, 1);
      model.push_back(data);
    end
  end

  // Model: every accepted read pops the queue; q must show it one rd_clk later
  always @(posedge rd_clk) begin
    if (reset_n && rd_en && !empty) begin
      chk("empty_pessimism", model.size() > 0, 1);
      if (model.size() > 0) begin
        exp_q = model.pop_front();
        popped.push_back(exp_q);
      end
    end
    #1;
    if (reset_n) chk("q_vs_model", q, exp_q);
  end

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    model.delete();
    popped.delete();
    exp_q   = '0;
    #100;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    repeat (4) @(negedge rd_clk);
  endtask

  task automatic wr_word(input logic [DW-1:0] d);
    int waits = 0;
    @(negedge clk);
    while (full && waits < 5000) begin
      @(negedge clk);
      waits++;
    end
    if (full) timeout_fail("wr_wait_not_full");
    wr_en = 1'b1;
    data  = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic rd_until(input int target, input bit gaps);
    int cyc = 0;
    while (popped.size() < target && cyc < 20000) begin
      @(negedge rd_clk);
      rd_en = (popped.size() < target) && (!gaps || $urandom_range(0, 3) != 0);
      cyc++;
    end
    @(negedge rd_clk);
    rd_en = 1'b0;
    if (popped.size() < target) timeout_fail("rd_until");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // Reset and empty read
    apply_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_q", q, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge rd_clk);
      rd_en = 1'b1;
      @(posedge rd_clk);
      #1;
      chk("empty_rd_q", q, 0);
      chk("empty_rd_empty", empty, 1);
    end
    @(negedge rd_clk);
    rd_en = 1'b0;

    // Frame packets: start-of-frame marker then n pixels
    for (int n = 1; n <= 15; n++) begin
      popped.delete();
      wr_word(17'h10000);
      for (int k = 0; k < n; k++) wr_word({1'b0, 16'($urandom_range(0, 65535))});
      chk("frame_full", full, 0);
      rd_until(n + 1, 1'b0);
      chk("frame_sof", popped[0], 17'h10000);
      chk("frame_len", popped.size(), n + 1);
      repeat (2) @(negedge rd_clk);
      chk("frame_empty", empty, 1);
    end

    // Empty latency and empty-on-last-pop
    popped.delete();
    @(negedge clk);
    data  = 17'h0ABCD;
    wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
    cnt = 0;
    while (empty && cnt < 10) begin
      @(posedge rd_clk);
      #1 cnt++;
    end
    chk("empty_latency_le4", cnt <= 4, 1);
    @(negedge rd_clk);
    rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    chk("latency_q", q, 17'h0ABCD);
    chk("latency_empty_on_pop", empty, 1);
    @(negedge rd_clk);
    rd_en = 1'b0;

    // Fill to full, overflow write dropped, drain
    popped.delete();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      data  = 17'(i);
      @(posedge clk);
      #1 wr_en = 1'b0;
      if (i == DEPTH - 2) chk("not_full_before_last", full, 0);
    end
    chk("full_after_1024", full, 1);
    @(negedge clk);
    wr_en = 1'b1;
    data  = 17'h1FFFF;
    @(posedge clk);
    #1 wr_en = 1'b0;
    chk("full_hold", full, 1);
    rd_until(DEPTH, 1'b0);
    repeat (6) begin
      @(negedge rd_clk);
      rd_en = 1'b1;
    end
    @(negedge rd_clk);
    rd_en = 1'b0;
    chk("drain_count", popped.size(), DEPTH);
    chk("drain_first", popped[0], 17'd0);
    chk("drain_last", popped[DEPTH-1], 17'd1023);
    chk("drain_empty", empty, 1);
    repeat (4) @(negedge clk);
    chk("full_released", full, 0);

    // Concurrent stream across pointer wrap
    popped.delete();
    fork
      for (int i = 0; i < 3000; i++) wr_word(17'(i));
      rd_until(3000, 1'b1);
    join
    chk("stream_count", popped.size(), 3000);
    chk("stream_last", popped[2999], 17'd2999);

    // Reset mid-operation
    popped.delete();
    for (int i = 0; i < 10; i++) wr_word(17'h00100 + 17'(i));
    rd_until(2, 1'b0);
    chk("pre_reset_q", q, 17'h00101);
    apply_reset();
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_q", q, 0);
    wr_word(17'h10000);
    wr_word(17'h00042);
    wr_word(17'h0FFFF);
    rd_until(3, 1'b0);
    chk("post_rst_w0", popped[0], 17'h10000);
    chk("post_rst_w1", popped[1], 17'h00042);
    chk("post_rst_w2", popped[2], 17'h0FFFF);
    repeat (2) @(negedge rd_clk);
    chk("post_rst_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_cam.md
Name: fifo_cam

Overview:
- Dual-clock FIFO carrying 17-bit camera words from the camera/pixel clock domain to the frame-buffer controller's load clock domain.
- Bit 16 is a control flag: 17'h10000 marks start of frame; bit16=0 carries a 16-bit pixel.
- Sits between the camera capture logic (writer, clk) and the video/frame-buffer controller (reader, rd_clk). It is a pure storage and CDC element and does not interpret data.

Parameters:
- DATA_WIDTH, 17, word width including the frame-marker bit.
- ADDR_WIDTH, 10, log2 of depth; depth = 2**ADDR_WIDTH = 1024 words.

Ports:
- clk  input  1  write clock (camera domain).
- reset_n  input  1  asynchronous active-low reset for both domains.
- rd_clk  input  1  read clock (frame-buffer load domain), asynchronous to clk.
- data  input  DATA_WIDTH  write data.
- wr_en  input  1  write request, sampled on rising clk.
- rd_en  input  1  read request, sampled on rising rd_clk.
- q  output  DATA_WIDTH  read data.
- empty  output  1  FIFO empty (rd_clk domain).
- full  output  1  FIFO full (clk domain).

Behaviour:
- Reset:
  - reset_n low asynchronously clears both binary and Gray pointers in both domains, and all synchronizer flops.
  - Reset values: q=0, empty=1, full=0.
  - Reset mid-operation discards all stored contents; the FIFO is empty after release.
  - Release is synchronized per domain with a 2-flop reset synchronizer: async assert, sync deassert.
- Storage: dual-port RAM of 2**ADDR_WIDTH x DATA_WIDTH. Written on clk, read on rd_clk.
- Write:
  - On rising clk with wr_en=1 and full=0: store data at wptr, then wptr++.
  - wr_en while full is ignored; no overwrite and no pointer change.
- Read (standard, non-first-word-fall-through):
  - On rising rd_clk with rd_en=1 and empty=0: q <= mem[rptr], then rptr++. Word is valid at q after that edge, i.e. 1 rd_clk latency.
  - q holds its value when no read occurs.
  - rd_en while empty is ignored; q and rptr are unchanged.
- Pointers:
  - ADDR_WIDTH+1 bits; MSB is the wrap bit.
  - Converted to Gray code (registered) before crossing domains.
  - Each Gray pointer crosses through a 2-flop synchronizer.
- Flag generation:
  - empty: registered in the rd_clk domain; set when next rgray == synchronized wgray. Updated on the same edge as the read, so it asserts the cycle the last word is popped.
  - full: registered in the clk domain; set when next wgray == synchronized rgray with its top two bits inverted.
- Flag latency and pessimism:
  - After the first write, empty deasserts within 3 rd_clk edges (Gray register plus 2 sync stages), plus at most 1 clk.
  - full deasserts within 3 clk edges after a read frees space.
  - Flags are pessimistic only; never report non-empty with no data, or non-full with no space.
- Simultaneous read and write of a non-empty, non-full FIFO: both succeed; occupancy unchanged.
- Wrap-around: pointers wrap modulo 2**(ADDR_WIDTH+1). Order is preserved across the RAM wrap.
- Ordering and integrity: strict FIFO order; all 17 bits, including bit 16, are preserved exactly.

Test Plan:
- Reset and empty read:
  - Pulse reset_n low, then release.
  - Require empty=1, full=0, q=0.
  - Drive rd_en=1 for 5 rd_clk cycles: q stays 0, empty stays 1.
- Frame packet:
  - Write 17'h10000 then n random 16-bit pixels, for each n = 1..15 (clk period 37 ns, rd_clk asynchronous).
  - full never asserts.
  - Reading until empty returns 17'h10000, then the pixels in order, each one rd_clk after its rd_en.
- Empty latency:
  - Write one word 17'h0ABCD into an empty FIFO.
  - empty falls within 4 rd_clk edges.
  - One read yields q=17'h0ABCD and empty=1 on that edge.
- Fill to full:
  - Write 1024 words 0..1023 without reading.
  - full=1 right after the 1024th write.
  - A 1025th write (value 17'h1FFFF) is dropped.
  - Draining returns 0..1023 exactly; 17'h1FFFF never appears.
- Wrap and concurrency:
  - Stream 3000 incrementing words with wr_en and rd_en both active, random rd_en gaps.
  - Output sequence is identical to input; no loss or duplication across pointer wrap.
- Reset mid-operation:
  - Load 10 words, then assert reset_n low.
  - After release: empty=1, full=0, q=0, and subsequent writes and reads behave as on a fresh FIFO.
